div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 26 ++
 rtl/div_core.sv | 78 +++++++
 rtl/div_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared opcode defines, FSM state encoding and payload types for the EX-stage divider.
package div_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned CNT_W  = 5;

    localparam logic [OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic [DATA_W-1:0] quo;
    } div_result_t;

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_core.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand magnitudes,
// sign-corrected result presented combinationally alongside the final step.
module div_core
    import div_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cancel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sign,
    output div_result_t       result,
    output logic              ready
);

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              qbit;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quo_n;

    // Operand magnitudes and one restoring step of the partial remainder.
    always_comb begin
        mag_a   = (sign && a[DATA_W-1]) ? DATA_W'(-a) : a;
        mag_b   = (sign && b[DATA_W-1]) ? DATA_W'(-b) : b;
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        qbit    = ~diff[DATA_W];
        rem_n   = qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_n   = {quo_q[DATA_W-2:0], qbit};
        ready   = busy && (cnt == CNT_W'(DATA_W - 1));
        result.quo = neg_q ? DATA_W'(-quo_n) : quo_n;
        result.rem = neg_r ? DATA_W'(-rem_n) : rem_n;
    end

    // Iteration registers; cnt wraps back to zero after the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (cancel) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= mag_a;
            dvs_q <= mag_b;
            neg_q <= sign & (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_r <= sign & a[DATA_W-1];
        end else if (busy) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt + CNT_W'(1);
            if (ready) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage divide controller: sequences div_core, stalls the pipeline while
// busy, and issues a single HI/LO write once the downstream stage can accept it.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                hold,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [OP_W-1:0]     op,
    output logic [2*DATA_W-1:0] div_result,
    output logic                divstall,
    output logic                hilo_we
);

    div_state_e  state;
    div_state_e  state_n;
    logic        core_start;
    logic        core_cancel;
    logic        core_ready;
    div_result_t core_result;
    logic        load_zero;
    logic        load_core;

    div_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .cancel (core_cancel),
        .a      (a),
        .b      (b),
        .sign   (op == EXE_DIV_OP),
        .result (core_result),
        .ready  (core_ready)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, stall/write-enable and datapath control; flush then reset override.
    always_comb begin
        state_n     = state;
        divstall    = 1'b0;
        hilo_we     = 1'b0;
        core_start  = 1'b0;
        core_cancel = 1'b0;
        load_zero   = 1'b0;
        load_core   = 1'b0;

        case (state)
            IDLE: begin
                if (is_div_op(op)) begin
                    divstall = 1'b1;
                    if (b == '0) begin
                        load_zero = 1'b1;
                        state_n   = DONE;
                    end else begin
                        core_start = 1'b1;
                        state_n    = BUSY;
                    end
                end
            end
            BUSY: begin
                divstall = 1'b1;
                if (core_ready) begin
                    load_core = 1'b1;
                    state_n   = DONE;
                end
            end
            DONE: begin
                if (!hold) begin
                    hilo_we = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (flush || rst) begin
            divstall    = 1'b0;
            hilo_we     = 1'b0;
            core_start  = 1'b0;
            core_cancel = 1'b1;
            load_zero   = 1'b0;
            load_core   = 1'b0;
            state_n     = IDLE;
        end
    end

    // Result register: divide-by-zero pattern or the corrected core result.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_result <= '0;
        end else if (load_zero) begin
            div_result <= {a, {DATA_W{1'b1}}};
        end else if (load_core) begin
            div_result <= {core_result.rem, core_result.quo};
        end
    end

endmodule
